// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding 64-bit read at a time, valid/ready hand-off to decode, PC redirect.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
module fetch_stage #(
    parameter int unsigned              CORE_ID  = 0,
    parameter int unsigned              ADDR_W   = 21,
    parameter logic [ADDR_W-1:0]        RESET_PC = '0,
    parameter int unsigned              INSN_W   = 64
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req_valid,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [7:0]          mem_req_core_id,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [INSN_W-1:0]   mem_rsp_data,
    output logic                dec_valid,
    output logic [INSN_W-1:0]   dec_insn,
    output logic [ADDR_W-1:0]   dec_pc,
    input  logic                dec_ready,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [31:0]         stat_wait_cycles,
    output logic [31:0]         stat_fetched
);

    localparam int unsigned STRIDE = INSN_W / 8;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   redirect_aligned;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(STRIDE - 1);

    assign mem_req_valid   = (state == REQ) && !rst;
    assign mem_req_addr    = pc;
    assign mem_req_core_id = 8'(CORE_ID);

    // Fetch FSM; redirect has priority over every other transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            dec_valid <= 1'b0;
            dec_insn  <= '0;
            dec_pc    <= '0;
        end else if (redirect_valid) begin
            pc        <= redirect_aligned;
            dec_valid <= 1'b0;
            case (state)
                REQ:   state <= mem_req_ready ? DRAIN : REQ;
                HOLD:  state <= REQ;
                // A response landing with the redirect is the stale one; nothing left to drain
                WAIT:  state <= mem_rsp_valid ? REQ : DRAIN;
                DRAIN: state <= mem_rsp_valid ? REQ : DRAIN;
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        dec_insn  <= mem_rsp_data;
                        dec_pc    <= pc;
                        dec_valid <= 1'b1;
                        pc        <= pc + ADDR_W'(STRIDE);
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (dec_valid && dec_ready) begin
                        dec_valid <= 1'b0;
                        state     <= REQ;
                    end
                end
                DRAIN: begin
                    if (mem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    // Memory-wait cycles and accepted instructions, both free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wait_cycles <= '0;
            stat_fetched     <= '0;
        end else begin
            if (state == WAIT || state == DRAIN) begin
                stat_wait_cycles <= stat_wait_cycles + 32'd1;
            end
            if (state == HOLD && dec_valid && dec_ready && !redirect_valid) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
        end
    end
`else
    assign stat_wait_cycles = '0;
    assign stat_fetched     = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; inputs change and outputs are sampled on the falling edge.
module tb_fetch_stage;

    logic          clk;
    logic          rst;
    logic          mem_req_valid;
    logic [20:0]   mem_req_addr;
    logic [7:0]    mem_req_core_id;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [63:0]   mem_rsp_data;
    logic          dec_valid;
    logic [63:0]   dec_insn;
    logic [20:0]   dec_pc;
    logic          dec_ready;
    logic          redirect_valid;
    logic [20:0]   redirect_pc;
    logic [31:0]   stat_wait_cycles;
    logic [31:0]   stat_fetched;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_core_id  (mem_req_core_id),
        .mem_req_ready    (mem_req_ready),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .dec_valid        (dec_valid),
        .dec_insn         (dec_insn),
        .dec_pc           (dec_pc),
        .dec_ready        (dec_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stat_wait_cycles (stat_wait_cycles),
        .stat_fetched     (stat_fetched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Drives one complete fetch from REQ: accept, `waits` WAIT cycles, capture HOLD outputs, accept by decode
    task automatic do_fetch(input logic [63:0] data, input int waits,
                            output logic v, output logic [63:0] insn, output logic [20:0] pc);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (waits - 1) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        v    = dec_valid;
        insn = dec_insn;
        pc   = dec_pc;
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b exp 0", mem_req_valid); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b exp 0", dec_valid); end
        checks++; if (dec_insn !== 64'h0 || dec_pc !== 21'h0) begin errors++; $display("FAIL reset_dec_data: got %h/%h exp 0/0", dec_insn, dec_pc); end
        checks++; if (stat_wait_cycles !== 32'd0 || stat_fetched !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d exp 0/0", stat_wait_cycles, stat_fetched); end
        rst = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 21'h0) begin errors++; $display("FAIL reset_first_req: got %b@%h exp 1@000000", mem_req_valid, mem_req_addr); end
        checks++; if (mem_req_core_id !== 8'd0) begin errors++; $display("FAIL core_id: got %h exp 00", mem_req_core_id); end
    endtask

    task automatic test_basic_fetch();
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL wait_no_req: got %b exp 0", mem_req_valid); end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h1122334455667788;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        checks++; if (dec_valid !== 1'b1 || dec_insn !== 64'h1122334455667788 || dec_pc !== 21'h0) begin
            errors++; $display("FAIL basic_dec: got %b %h pc %h exp 1 1122334455667788 pc 000000", dec_valid, dec_insn, dec_pc); end
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL basic_dec_clear: got %b exp 0", dec_valid); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 21'h8) begin errors++; $display("FAIL basic_next_req: got %b@%h exp 1@000008", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_decode_stall();
        int bad = 0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hA5A5_0000_DEAD_BEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (dec_valid !== 1'b1 || dec_insn !== 64'hA5A5_0000_DEAD_BEEF || dec_pc !== 21'h8 || mem_req_valid !== 1'b0) begin
                bad++; $display("FAIL stall_cycle%0d: got v=%b %h pc %h req=%b exp v=1 a5a50000deadbeef pc 000008 req=0", i, dec_valid, dec_insn, dec_pc, mem_req_valid);
            end
            @(negedge clk);
        end
        checks++; if (bad != 0) errors++;
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 21'h10) begin errors++; $display("FAIL stall_next_req: got %b@%h exp 1@000010", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        logic v; logic [63:0] insn; logic [20:0] pc;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 21'h0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_no_req: got %b exp 0", mem_req_valid); end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hBAD0BAD0BAD0BAD0;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL drain_discard: got dec_valid %b exp 0", dec_valid); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 21'h100) begin errors++; $display("FAIL redirect_wait_req: got %b@%h exp 1@000100", mem_req_valid, mem_req_addr); end
        do_fetch(64'h0123456789ABCDEF, 1, v, insn, pc);
        checks++; if (v !== 1'b1 || insn !== 64'h0123456789ABCDEF || pc !== 21'h100) begin errors++; $display("FAIL redirect_wait_fetch: got %b %h pc %h exp 1 0123456789abcdef pc 000100", v, insn, pc); end
    endtask

    task automatic test_redirect_hold();
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hFEEDFACECAFEF00D;
        @(negedge clk);
        mem_rsp_valid  = 1'b0;
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 21'h0043;
        @(negedge clk);
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL hold_redirect_drop: got %b exp 0", dec_valid); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 21'h40) begin errors++; $display("FAIL hold_redirect_req: got %b@%h exp 1@000040", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_wrap();
        logic v; logic [63:0] insn; logic [20:0] pc;
        redirect_valid = 1'b1;
        redirect_pc    = 21'h1FFFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 21'h1FFFF8) begin errors++; $display("FAIL wrap_req: got %b@%h exp 1@1ffff8", mem_req_valid, mem_req_addr); end
        do_fetch(64'h7777777788888888, 1, v, insn, pc);
        checks++; if (v !== 1'b1 || pc !== 21'h1FFFF8) begin errors++; $display("FAIL wrap_dec_pc: got %b pc %h exp 1 pc 1ffff8", v, pc); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 21'h0) begin errors++; $display("FAIL wrap_next_req: got %b@%h exp 1@000000", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_reset_midflight();
        mem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 21'h0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h5555AAAA5555AAAA;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 21'h0) begin errors++; $display("FAIL midreset_req: got %b@%h exp 1@000000", mem_req_valid, mem_req_addr); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0 || mem_req_valid !== 1'b1) begin errors++; $display("FAIL midreset_ignore_rsp: got dec_valid %b req %b exp 0 1", dec_valid, mem_req_valid); end
    endtask

    task automatic test_stats();
        logic v; logic [63:0] insn; logic [20:0] pc;
        logic [31:0] exp_fetched;
        logic [31:0] exp_wait;
`ifdef FETCH_STATS_EN
        exp_fetched = 32'd3;
        exp_wait    = 32'd6;
`else
        exp_fetched = 32'd0;
        exp_wait    = 32'd0;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_fetch(64'h1000 + 64'(i), 2, v, insn, pc);
            checks++; if (v !== 1'b1 || pc !== 21'(i * 8)) begin errors++; $display("FAIL stats_fetch%0d: got %b pc %h exp 1 pc %h", i, v, pc, 21'(i * 8)); end
        end
        checks++; if (stat_fetched !== exp_fetched) begin errors++; $display("FAIL stat_fetched: got %0d exp %0d", stat_fetched, exp_fetched); end
        checks++; if (stat_wait_cycles !== exp_wait) begin errors++; $display("FAIL stat_wait_cycles: got %0d exp %0d", stat_wait_cycles, exp_wait); end
    endtask

    initial begin
        rst            = 1'b1;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(negedge clk);
        test_reset();
        test_basic_fetch();
        test_decode_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_midflight();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
